// File: rtl/risc16_mem_arbiter.sv
// risc16_mem_arbiter: shares one single-port word RAM between the RISC16F fetch and data ports.
// Define RISC16_LED_MMIO_EN to decode the LED registers at LED_BASE/LED_BASE+2 instead of RAM.
module risc16_mem_arbiter #(
  parameter int          MEM_AW   = 15,
  parameter logic [15:0] LED_BASE = 16'h0200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       iaddr,
  input  logic              ioe,
  output logic [15:0]       idin,
  output logic              i_stall,
  input  logic [15:0]       daddr,
  input  logic [15:0]       ddout,
  input  logic              doe,
  input  logic              dwe,
  output logic [15:0]       ddin,
  output logic              d_stall,
  output logic [MEM_AW-1:0] maddr,
  output logic              mre,
  output logic              mwe,
  output logic [15:0]       mwdata,
  input  logic [15:0]       mrdata,
  output logic [23:0]       led
);
`ifdef RISC16_LED_MMIO_EN
  localparam logic MMIO = 1'b1;
`else
  localparam logic MMIO = 1'b0;
`endif
  localparam logic [15:0] LED_MODE_ADDR = LED_BASE + 16'd2;
  typedef enum logic [1:0] {R_NONE, R_I, R_D, R_MMIO} ret_t;
  ret_t        ret_q, ret_d;
  logic [23:0] led_q, led_d;
  logic [15:0] mmio_q, mmio_d;
  logic        i_done, d_done, i_req, d_req, d_hi, d_mmio, unused_ok;
  assign unused_ok = ^{iaddr[0], daddr[0]};
  assign idin      = mrdata;
  assign mwdata    = ddout;
  assign ddin      = ret_q == R_MMIO ? mmio_q : mrdata;
  assign led       = MMIO ? led_q : 24'h0;
  // A port whose data returns this cycle sits out arbitration; data outranks fetch.
  always_comb begin
    i_done  = ret_q == R_I;
    d_done  = ret_q == R_D || ret_q == R_MMIO;
    i_req   = ioe && !i_done;
    d_req   = (doe || dwe) && !d_done;
    d_hi    = daddr[15:1] == LED_MODE_ADDR[15:1];
    d_mmio  = MMIO && (d_hi || daddr[15:1] == LED_BASE[15:1]);
    ret_d   = R_NONE;
    led_d   = led_q;
    mmio_d  = mmio_q;
    mre     = 1'b0;
    mwe     = 1'b0;
    maddr   = daddr[MEM_AW:1];
    if (!rst && d_req) begin
      if (dwe) begin
        mwe   = !d_mmio;
        led_d = !d_mmio ? led_q : d_hi ? {ddout[7:0], led_q[15:0]} : {led_q[23:16], ddout};
      end else begin
        mre    = !d_mmio;
        ret_d  = d_mmio ? R_MMIO : R_D;
        mmio_d = d_hi ? {8'h00, led_q[23:16]} : led_q[15:0];
      end
    end else if (!rst && i_req) begin
      mre   = 1'b1;
      maddr = iaddr[MEM_AW:1];
      ret_d = R_I;
    end
    i_stall = rst ? ioe : i_req;
    d_stall = rst ? (doe || dwe) : d_req && !dwe;
  end
  always_ff @(posedge clk) begin
    ret_q  <= rst ? R_NONE : ret_d;
    led_q  <= rst ? 24'h0 : led_d;
    mmio_q <= rst ? 16'h0 : mmio_d;
  end
endmodule

// File: tb/tb_risc16_mem_arbiter.sv
// tb_risc16_mem_arbiter: directed scenarios plus a randomized CPU-like driver checked against a word-array memory model.
module tb_risc16_mem_arbiter;
`ifdef RISC16_LED_MMIO_EN
  localparam logic MMIO = 1'b1;
`else
  localparam logic MMIO = 1'b0;
`endif
  logic        clk = 1'b0, rst, ioe, doe, dwe, i_stall, d_stall, mre, mwe, pl_we;
  logic [15:0] iaddr, daddr, ddout, idin, ddin, mwdata, mrdata, pl_data;
  logic [14:0] maddr, pl_addr;
  logic [23:0] led;
  logic [15:0] ram [0:32767];
  logic [15:0] ref_mem [0:63];
  int checks = 0, failures = 0;

  risc16_mem_arbiter dut (
    .clk(clk), .rst(rst), .iaddr(iaddr), .ioe(ioe), .idin(idin), .i_stall(i_stall),
    .daddr(daddr), .ddout(ddout), .doe(doe), .dwe(dwe), .ddin(ddin), .d_stall(d_stall),
    .maddr(maddr), .mre(mre), .mwe(mwe), .mwdata(mwdata), .mrdata(mrdata), .led(led)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM macro with a bench-only preload port.
  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (mwe) ram[maddr] <= mwdata;
    if (mre) mrdata <= ram[maddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] fexp [0:2];
    logic        f_act, d_act, d_st;
    logic [15:0] f_a, d_a, d_v;
    int          f_age, d_age, f_cool, d_cool;
    fexp[0] = 16'h1111; fexp[1] = 16'h2222; fexp[2] = 16'h3333;
    rst = 1; ioe = 1; doe = 0; dwe = 0; iaddr = 0; daddr = 0; ddout = 0;
    pl_we = 0; pl_addr = 0; pl_data = 0;
    tick; #1;
    chk("rst_mre", mre, 0); chk("rst_mwe", mwe, 0); chk("rst_i_stall", i_stall, 1);
    chk("rst_d_stall_idle", d_stall, 0); chk("rst_led", led, 0);
    dwe = 1; #1;
    chk("rst_d_stall_req", d_stall, 1); chk("rst_mwe_req", mwe, 0);
    dwe = 0;
    pl_we = 1;
    for (int i = 0; i < 5; i++) begin
      pl_addr = i < 4 ? 15'(i) : 15'h8;
      pl_data = i < 4 ? 16'h1111 * 16'(i + 1) : 16'hBEEF;
      tick;
    end
    pl_we = 0; rst = 0;
    // Fetch-only stream: issue, complete, issue, ...
    for (int k = 0; k < 3; k++) begin
      iaddr = 16'(2 * k); #1;
      chk("fo_mre", mre, 1); chk("fo_maddr", maddr, k); chk("fo_stall", i_stall, 1); chk("fo_mwe", mwe, 0);
      tick; #1;
      chk("fo_idin", idin, fexp[k]); chk("fo_done", i_stall, 0); chk("fo_no_mre", mre, 0); chk("fo_mwe2", mwe, 0);
      tick;
    end
    // Load and fetch together: data first, fetch overlaps the load return.
    iaddr = 16'h0004; doe = 1; daddr = 16'h0010; #1;
    chk("lf_mre", mre, 1); chk("lf_maddr", maddr, 15'h08); chk("lf_d_stall", d_stall, 1); chk("lf_i_stall", i_stall, 1);
    tick; #1;
    chk("lf_ddin", ddin, 16'hBEEF); chk("lf_d_done", d_stall, 0); chk("lf_f_mre", mre, 1);
    chk("lf_f_maddr", maddr, 15'h02); chk("lf_f_stall", i_stall, 1);
    tick; doe = 0; #1;
    chk("lf_idin", idin, 16'h3333); chk("lf_i_done", i_stall, 0);
    // Zero-wait store while a fetch waits.
    tick; iaddr = 16'h0006; dwe = 1; daddr = 16'h0020; ddout = 16'hA5A5; #1;
    chk("st_mwe", mwe, 1); chk("st_maddr", maddr, 15'h10); chk("st_wdata", mwdata, 16'hA5A5);
    chk("st_d_stall", d_stall, 0); chk("st_i_stall", i_stall, 1); chk("st_mre", mre, 0);
    tick; dwe = 0; #1;
    chk("st_f_mre", mre, 1); chk("st_f_maddr", maddr, 15'h03); chk("st_f_stall", i_stall, 1);
    tick; #1;
    chk("st_f_idin", idin, 16'h4444);
    tick; ioe = 0; doe = 1; daddr = 16'h0020; #1;
    chk("rb_mre", mre, 1); chk("rb_maddr", maddr, 15'h10); chk("rb_stall", d_stall, 1);
    tick; #1;
    chk("rb_ddin", ddin, 16'hA5A5); chk("rb_done", d_stall, 0);
    // LED registers (RAM stores when the feature is absent).
    tick; doe = 0; dwe = 1; daddr = 16'h0200; ddout = 16'h1234; #1;
    chk("led0_mwe", mwe, !MMIO); chk("led0_stall", d_stall, 0);
    tick; daddr = 16'h0202; ddout = 16'h0056; #1;
    chk("led1_mwe", mwe, !MMIO);
    tick; dwe = 0; doe = 1; #1;
    chk("led_val", led, MMIO ? 24'h561234 : 24'h0); chk("led_ld_mre", mre, !MMIO); chk("led_ld_stall", d_stall, 1);
    tick; #1;
    chk("led_ld_ddin", ddin, 16'h0056); chk("led_ld_done", d_stall, 0);
    // Reset one cycle after a load issues.
    tick; daddr = 16'h0010; #1;
    chk("rl_mre", mre, 1); chk("rl_stall", d_stall, 1);
    tick; rst = 1; #1;
    chk("rl_rst_mre", mre, 0); chk("rl_rst_mwe", mwe, 0); chk("rl_rst_d_stall", d_stall, 1); chk("rl_rst_i_stall", i_stall, 0);
    tick; rst = 0; #1;
    chk("rl_led", led, 0); chk("rl_reissue", mre, 1); chk("rl_maddr", maddr, 15'h08); chk("rl_stall2", d_stall, 1);
    tick; #1;
    chk("rl_ddin", ddin, 16'hBEEF); chk("rl_done", d_stall, 0);
    // doe and dwe together at an odd address act as a word store.
    tick; dwe = 1; daddr = 16'h0031; ddout = 16'h7777; #1;
    chk("dw_mwe", mwe, 1); chk("dw_mre", mre, 0); chk("dw_stall", d_stall, 0); chk("dw_maddr", maddr, 15'h18);
    tick; dwe = 0; daddr = 16'h0030; #1;
    chk("dw_ld_maddr", maddr, 15'h18);
    tick; #1;
    chk("dw_ld_ddin", ddin, 16'h7777);
    // Fetch abandoned while its read is in flight.
    tick; doe = 0; ioe = 1; iaddr = 16'h0000; #1;
    chk("ab_mre", mre, 1); chk("ab_maddr", maddr, 0);
    tick; ioe = 0; #1;
    chk("ab_i_stall", i_stall, 0);
    tick; doe = 1; daddr = 16'h0010; #1;
    chk("ab_ld_mre", mre, 1); chk("ab_ld_stall", d_stall, 1);
    tick; #1;
    chk("ab_ld_ddin", ddin, 16'hBEEF);
    tick; doe = 0;
    // Randomized traffic against the word-array model.
    rst = 1; pl_we = 1;
    for (int i = 0; i < 64; i++) begin
      pl_addr = 15'(i); pl_data = 16'($urandom); ref_mem[i] = pl_data;
      tick;
    end
    pl_we = 0; rst = 0;
    f_act = 0; d_act = 0; d_st = 0; f_a = 0; d_a = 0; d_v = 0;
    f_age = 0; d_age = 0; f_cool = 0; d_cool = 0;
    for (int n = 0; n < 600; n++) begin
      ioe = f_act; iaddr = f_a;
      dwe = d_act && d_st; doe = d_act && (!d_st || $urandom_range(0, 1) == 1);
      daddr = d_a; ddout = d_v;
      #1;
      if (mre && mwe) chk("rnd_excl", mwe, 0);
      if (!(d_act && d_st)) chk("rnd_no_mwe", mwe, 0);
      if (f_act) begin
        f_age++;
        if (!i_stall) begin
          chk("rnd_idin", idin, ref_mem[f_a[6:1]]); f_act = 0;
        end else if (f_age > 20) begin
          chk("rnd_fetch_timeout", i_stall, 0); f_act = 0; f_cool = 2;
        end else if ($urandom_range(0, 15) == 0) begin
          f_act = 0; f_cool = 2;
        end
      end
      if (d_act) begin
        d_age++;
        if (!d_stall && d_st) begin
          chk("rnd_st_mwe", mwe, 1); chk("rnd_st_maddr", maddr, d_a[15:1]); chk("rnd_st_wdata", mwdata, d_v);
          ref_mem[d_a[6:1]] = d_v; d_act = 0;
        end else if (!d_stall) begin
          chk("rnd_ddin", ddin, ref_mem[d_a[6:1]]); d_act = 0;
        end else if (d_age > 20) begin
          chk("rnd_data_timeout", d_stall, 0); d_act = 0; d_cool = 2;
        end else if ($urandom_range(0, 15) == 0) begin
          d_act = 0; d_cool = 2;
        end
      end
      if (!f_act) begin
        if (f_cool > 0) f_cool--;
        else if ($urandom_range(0, 3) != 0) begin
          f_act = 1; f_age = 0; f_a = 16'($urandom_range(0, 127));
        end
      end
      if (!d_act) begin
        if (d_cool > 0) d_cool--;
        else if ($urandom_range(0, 2) != 0) begin
          d_act = 1; d_age = 0; d_st = $urandom_range(0, 1) == 1;
          d_a = 16'($urandom_range(0, 127)); d_v = 16'($urandom);
        end
      end
      tick;
    end
    ioe = 0; doe = 0; dwe = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
